// File: rtl/spart_pkg.sv
// Shared types, bus address map and baud divisor helper for the SPART host driver.
package spart_pkg;

    typedef enum logic [2:0] {
        CFG_LO,
        CFG_HI,
        IDLE,
        RD,
        WR,
        HOLD
    } state_t;

    localparam logic [1:0] ADDR_BUF  = 2'b00;
    localparam logic [1:0] ADDR_STAT = 2'b01;
    localparam logic [1:0] ADDR_DBL  = 2'b10;
    localparam logic [1:0] ADDR_DBH  = 2'b11;

    // sel picks 4800 << sel baud; integer division truncates toward zero.
    function automatic logic [15:0] divisor(input int unsigned clk_freq, input logic [1:0] sel);
        int unsigned baud;
        baud = 32'd4800 << sel;
        return 16'(clk_freq / (32'd16 * baud) - 32'd1);
    endfunction

endpackage

// File: rtl/spart_if.sv
// SPART processor bus: one access per iocs pulse, split read and write data.
// Handshake: an access is the single cycle with iocs=1; rdata is valid in that cycle, wdata while iorw=0.
interface spart_if;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       rda;
    logic       tbr;

    modport master (
        output iocs, iorw, ioaddr, wdata,
        input  rdata, rda, tbr
    );

    modport slave (
        input  iocs, iorw, ioaddr, wdata,
        output rdata, rda, tbr
    );
endinterface

// File: rtl/spart_echo_fifo.sv
// Circular byte queue holding received bytes until they are written back out.
module spart_echo_fifo #(
    parameter  int FIFO_DEPTH = 4,
    localparam int AW         = $clog2(FIFO_DEPTH),
    localparam int CW         = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    din,
    output logic [7:0]    head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    assign full  = (count_q == CW'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

    // Pointers wrap for free because the depth is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push && !full) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            count_d  = count_q + 1'b1;
        end
        if (pop && !empty) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            count_d  = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push && !full) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/spart_driver.sv
// Host controller: programs the SPART baud divisor, then echoes received bytes
// back out, alternating RX reads and TX writes on the shared bus.
module spart_driver
    import spart_pkg::*;
#(
    parameter  int unsigned CLK_FREQ   = 50_000_000,
    parameter  int          FIFO_DEPTH = 4,
    localparam int          CW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    br_cfg,
    spart_if.master       bus,
    output logic          cfg_done,
    output logic [CW-1:0] fifo_count,
    output state_t        dbg_state
);

    localparam logic [15:0] DIV0 = divisor(CLK_FREQ, 2'd0);
    localparam logic [15:0] DIV1 = divisor(CLK_FREQ, 2'd1);
    localparam logic [15:0] DIV2 = divisor(CLK_FREQ, 2'd2);
    localparam logic [15:0] DIV3 = divisor(CLK_FREQ, 2'd3);

    function automatic logic [15:0] div_of(input logic [1:0] sel);
        case (sel)
            2'd0:    return DIV0;
            2'd1:    return DIV1;
            2'd2:    return DIV2;
            default: return DIV3;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic        active_q;
    logic [1:0]  cfg_q, cfg_d;
    logic        cfg_done_q, cfg_done_d;
    logic        last_wr_q, last_wr_d;
    logic [7:0]  wdata_q, wdata_d;

    logic        iocs, iorw;
    logic [1:0]  ioaddr;
    logic        push, pop;
    logic        rd_ok, wr_ok;
    logic [15:0] div_new, div_old;
    logic [7:0]  fifo_head;
    logic        fifo_full, fifo_empty;

    assign rd_ok   = bus.rda && !fifo_full;
    assign wr_ok   = bus.tbr && !fifo_empty;
    assign div_new = div_of(br_cfg);
    assign div_old = div_of(cfg_q);

    // active_q keeps the bus quiet for the first cycle after reset so the
    // reset-time outputs are visible before CFG_LO drives the bus.
    always_comb begin
        state_d    = state_q;
        cfg_d      = cfg_q;
        cfg_done_d = cfg_done_q;
        last_wr_d  = last_wr_q;
        iocs       = 1'b0;
        iorw       = 1'b1;
        ioaddr     = ADDR_BUF;
        wdata_d    = wdata_q;
        push       = 1'b0;
        pop        = 1'b0;
        case (state_q)
            CFG_LO: begin
                if (active_q) begin
                    iocs    = 1'b1;
                    iorw    = 1'b0;
                    ioaddr  = ADDR_DBL;
                    wdata_d = div_new[7:0];
                    cfg_d   = br_cfg;
                    state_d = CFG_HI;
                end
            end
            CFG_HI: begin
                iocs       = 1'b1;
                iorw       = 1'b0;
                ioaddr     = ADDR_DBH;
                wdata_d    = div_old[15:8];
                cfg_done_d = 1'b1;
                state_d    = HOLD;
            end
            IDLE: begin
                if (br_cfg != cfg_q) begin
                    cfg_done_d = 1'b0;
                    state_d    = CFG_LO;
                end else if (rd_ok && (!wr_ok || last_wr_q)) begin
                    last_wr_d = 1'b0;
                    state_d   = RD;
                end else if (wr_ok) begin
                    last_wr_d = 1'b1;
                    state_d   = WR;
                end
            end
            RD: begin
                iocs    = 1'b1;
                push    = 1'b1;
                state_d = HOLD;
            end
            WR: begin
                iocs    = 1'b1;
                iorw    = 1'b0;
                wdata_d = fifo_head;
                pop     = 1'b1;
                state_d = HOLD;
            end
            HOLD:    state_d = IDLE;
            default: state_d = CFG_LO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= CFG_LO;
            active_q   <= 1'b0;
            cfg_q      <= 2'b00;
            cfg_done_q <= 1'b0;
            last_wr_q  <= 1'b1;
            wdata_q    <= 8'h00;
        end else begin
            state_q    <= state_d;
            active_q   <= 1'b1;
            cfg_q      <= cfg_d;
            cfg_done_q <= cfg_done_d;
            last_wr_q  <= last_wr_d;
            wdata_q    <= wdata_d;
        end
    end

    spart_echo_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (bus.rdata),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign bus.iocs   = iocs;
    assign bus.iorw   = iorw;
    assign bus.ioaddr = ioaddr;
    assign bus.wdata  = wdata_d;
    assign cfg_done   = cfg_done_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_spart_driver.sv
// Directed bench for spart_driver: configuration, echo path, arbitration, reconfig and reset.
module tb_spart_driver;
    import spart_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [1:0] br_cfg;
    logic       cfg_done;
    logic [2:0] fifo_count;
    state_t     dbg_state;

    spart_if bus ();

    spart_driver #(.CLK_FREQ(50_000_000), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .br_cfg     (br_cfg),
        .bus        (bus),
        .cfg_done   (cfg_done),
        .fifo_count (fifo_count),
        .dbg_state  (dbg_state)
    );

    int         n_cmp;
    int         n_err;
    int         cyc;
    logic [7:0] exp_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before 100000ns");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int         reads;
        int         writes;
        int         npulse;
        int         kind;
        int         prev_kind;
        int         last_t;
        bit         have_prev;
        bit         adv;
        bit         found;
        logic [7:0] e;

        n_cmp = 0;
        n_err = 0;
        cyc   = 0;
        adv   = 1'b0;
        rst_n = 1'b0;
        br_cfg = 2'b01;
        bus.rda   = 1'b0;
        bus.tbr   = 1'b0;
        bus.rdata = 8'h00;

        // ---- reset values and divisor programming (br_cfg=01 -> 324) ----
        tick();
        tick();
        check("rst_iocs",   16'(bus.iocs),   16'd0);
        check("rst_iorw",   16'(bus.iorw),   16'd1);
        check("rst_ioaddr", 16'(bus.ioaddr), 16'd0);
        check("rst_wdata",  16'(bus.wdata),  16'h00);
        check("rst_cfg_done", 16'(cfg_done), 16'd0);
        check("rst_fifo_count", 16'(fifo_count), 16'd0);
        rst_n = 1'b1;
        tick();
        check("cfglo_iocs",   16'(bus.iocs),   16'd1);
        check("cfglo_iorw",   16'(bus.iorw),   16'd0);
        check("cfglo_ioaddr", 16'(bus.ioaddr), 16'd2);
        check("cfglo_wdata",  16'(bus.wdata),  16'h44);
        tick();
        check("cfghi_iocs",   16'(bus.iocs),   16'd1);
        check("cfghi_ioaddr", 16'(bus.ioaddr), 16'd3);
        check("cfghi_wdata",  16'(bus.wdata),  16'h01);
        check("cfghi_cfg_done", 16'(cfg_done), 16'd0);
        tick();
        check("hold_iocs",     16'(bus.iocs),  16'd0);
        check("hold_cfg_done", 16'(cfg_done),  16'd1);
        check("hold_wdata_kept", 16'(bus.wdata), 16'h01);
        check("hold_ioaddr",   16'(bus.ioaddr), 16'd0);
        check("hold_state",    16'(dbg_state), 16'(HOLD));
        npulse = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            npulse += int'(bus.iocs);
        end
        check("quiet_pulses", 16'(npulse), 16'd0);

        // ---- single echo: rdata=A5 ----
        bus.rda   = 1'b1;
        bus.rdata = 8'hA5;
        bus.tbr   = 1'b1;
        tick();
        check("echo_rd_iocs",   16'(bus.iocs),   16'd1);
        check("echo_rd_iorw",   16'(bus.iorw),   16'd1);
        check("echo_rd_ioaddr", 16'(bus.ioaddr), 16'd0);
        check("echo_rd_count",  16'(fifo_count), 16'd0);
        bus.rda = 1'b0;
        tick();
        check("echo_hold_count", 16'(fifo_count), 16'd1);
        tick();
        check("echo_idle_iocs", 16'(bus.iocs), 16'd0);
        tick();
        check("echo_wr_iocs",   16'(bus.iocs),   16'd1);
        check("echo_wr_iorw",   16'(bus.iorw),   16'd0);
        check("echo_wr_ioaddr", 16'(bus.ioaddr), 16'd0);
        check("echo_wr_wdata",  16'(bus.wdata),  16'hA5);
        tick();
        check("echo_after_count", 16'(fifo_count), 16'd0);
        bus.tbr = 1'b0;

        // ---- fill with tbr=0: only 4 reads of 11..14 ----
        bus.rda   = 1'b1;
        bus.rdata = 8'h11;
        reads  = 0;
        writes = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (adv) begin
                bus.rdata = bus.rdata + 8'd1;
                adv = 1'b0;
            end
            if (bus.iocs && bus.iorw) begin
                exp_q.push_back(bus.rdata);
                reads++;
                adv = 1'b1;
            end
            if (bus.iocs && !bus.iorw) writes++;
        end
        check("fill_reads",  16'(reads),      16'd4);
        check("fill_writes", 16'(writes),     16'd0);
        check("fill_count",  16'(fifo_count), 16'd4);

        // ---- interleaved drain: alternate RD/WR every 3 cycles ----
        bus.tbr   = 1'b1;
        have_prev = 1'b0;
        prev_kind = 0;
        last_t    = 0;
        writes    = 0;
        for (int i = 0; i < 100 && writes < 10; i++) begin
            tick();
            if (adv) begin
                bus.rdata = bus.rdata + 8'd1;
                adv = 1'b0;
            end
            if (bus.iocs) begin
                kind = bus.iorw ? 1 : 0;
                if (have_prev) begin
                    check("access_gap", 16'(cyc - last_t), 16'd3);
                    if (reads < 10) check("alternate", 16'(kind != prev_kind), 16'd1);
                end
                if (kind == 1) begin
                    exp_q.push_back(bus.rdata);
                    reads++;
                    adv = 1'b1;
                    if (reads == 10) bus.rda = 1'b0;
                end else begin
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                    check("echo_data", 16'(bus.wdata), 16'(e));
                    if (writes < 4) check("echo_order", 16'(bus.wdata), 16'(8'h11 + 8'(writes)));
                    writes++;
                end
                have_prev = 1'b1;
                prev_kind = kind;
                last_t    = cyc;
            end
        end
        check("drain_writes", 16'(writes), 16'd10);
        check("drain_reads",  16'(reads),  16'd10);
        tick();
        check("drain_count",  16'(fifo_count), 16'd0);
        check("drain_sb_left", 16'(exp_q.size()), 16'd0);
        bus.tbr = 1'b0;
        adv     = 1'b0;

        // ---- reconfigure to 38400 with 2 bytes queued ----
        bus.rda   = 1'b1;
        bus.rdata = 8'h61;
        reads = 0;
        for (int i = 0; i < 30 && reads < 2; i++) begin
            tick();
            if (adv) begin
                bus.rdata = bus.rdata + 8'd1;
                adv = 1'b0;
            end
            if (bus.iocs && bus.iorw) begin
                exp_q.push_back(bus.rdata);
                reads++;
                adv = 1'b1;
                if (reads == 2) bus.rda = 1'b0;
            end
        end
        check("recfg_reads", 16'(reads), 16'd2);
        adv    = 1'b0;
        br_cfg = 2'b11;
        found  = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (bus.iocs) found = 1'b1;
        end
        check("recfg_seen",     16'(found),       16'd1);
        check("recfg_cfg_done", 16'(cfg_done),    16'd0);
        check("recfg_lo_addr",  16'(bus.ioaddr),  16'd2);
        check("recfg_lo_iorw",  16'(bus.iorw),    16'd0);
        check("recfg_lo_wdata", 16'(bus.wdata),   16'h50);
        check("recfg_count",    16'(fifo_count),  16'd2);
        tick();
        check("recfg_hi_addr",  16'(bus.ioaddr),  16'd3);
        check("recfg_hi_wdata", 16'(bus.wdata),   16'h00);
        tick();
        check("recfg_done",     16'(cfg_done),    16'd1);
        bus.tbr = 1'b1;
        writes  = 0;
        for (int i = 0; i < 30 && writes < 2; i++) begin
            tick();
            if (bus.iocs && !bus.iorw) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                check("recfg_echo_data", 16'(bus.wdata), 16'(e));
                check("recfg_echo_hand", 16'(bus.wdata), 16'(8'h61 + 8'(writes)));
                writes++;
            end
        end
        check("recfg_writes", 16'(writes), 16'd2);
        bus.tbr = 1'b0;

        // ---- reset in the middle of a read ----
        bus.rda   = 1'b1;
        bus.rdata = 8'h77;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (bus.iocs && bus.iorw) found = 1'b1;
        end
        check("mid_rd_seen", 16'(found), 16'd1);
        rst_n   = 1'b0;
        bus.rda = 1'b0;
        tick();
        check("mid_rst_iocs",   16'(bus.iocs),   16'd0);
        check("mid_rst_count",  16'(fifo_count), 16'd0);
        check("mid_rst_cfg_done", 16'(cfg_done), 16'd0);
        check("mid_rst_wdata",  16'(bus.wdata),  16'h00);
        rst_n = 1'b1;
        tick();
        check("mid_cfglo_iocs",  16'(bus.iocs),   16'd1);
        check("mid_cfglo_addr",  16'(bus.ioaddr), 16'd2);
        check("mid_cfglo_wdata", 16'(bus.wdata),  16'h50);
        check("mid_cfglo_count", 16'(fifo_count), 16'd0);
        tick();
        check("mid_cfghi_addr",  16'(bus.ioaddr), 16'd3);
        tick();
        check("mid_cfg_done",    16'(cfg_done),   16'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
